// File: rtl/gatorga_pkg.sv
// gatorga_pkg
//   Shared types for the gatorga game core.
//   - GP_X_W / GP_Y_W : default coordinate widths (bullet_t is built on these)
//   - SCREEN_W / SCREEN_H : visible raster size
//   - sched_state_e : bullet scheduler FSM states
//   - bullet_t : one bullet slot {active, x, y}
package gatorga_pkg;

  localparam int GP_X_W   = 10;
  localparam int GP_Y_W   = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic              active;
    logic [GP_X_W-1:0] x;
    logic [GP_Y_W-1:0] y;
  } bullet_t;

endpackage

// File: rtl/bullet_slot_alloc.sv
// bullet_slot_alloc
//   Lowest-index free-slot priority encoder for the bullet pool.
//   Ports:
//     live_mask  in   NUM_BULLETS  per-slot active flags
//     free_idx   out  IDX_W        lowest slot with live_mask==0 (0 when none free)
//     any_free   out  1            at least one slot is free
module bullet_slot_alloc #(
  parameter int NUM_BULLETS = 4,
  parameter int IDX_W       = $clog2(NUM_BULLETS)
) (
  input  logic [NUM_BULLETS-1:0] live_mask,
  output logic [IDX_W-1:0]       free_idx,
  output logic                   any_free
);

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_BULLETS-1; i >= 0; i--) begin
      if (!live_mask[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler
//   Player-bullet pool: turns fire edges into rate-limited spawns, allocates the
//   lowest free slot, and once per frame walks the slots moving bullets upward
//   and retiring the ones that would leave the top of the screen.
//   Ports:
//     clk125, rst_n   clock / async active-low reset
//     frame_tick      1-cycle pulse at vblank start
//     fire            synchronised fire button level
//     ship_x          ship x, sampled at spawn
//     hit_valid/slot  collision report, clears that slot's active flag
//     bullet_active   per-slot live flag
//     bullet_x/_y     packed coordinates, slot i at [i*W +: W]
//     fire_ack        1-cycle pulse when a shot spawns
//     update_busy     high while the per-frame slot walk runs
module bullet_scheduler
  import gatorga_pkg::*;
#(
  parameter int NUM_BULLETS     = 4,
  parameter int X_W             = GP_X_W,
  parameter int Y_W             = GP_Y_W,
  parameter int SHIP_Y          = 440,
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                           clk125,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic                           fire,
  input  logic [X_W-1:0]                 ship_x,
  input  logic                           hit_valid,
  input  logic [$clog2(NUM_BULLETS)-1:0] hit_slot,
  output logic [NUM_BULLETS-1:0]         bullet_active,
  output logic [NUM_BULLETS*X_W-1:0]     bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0]     bullet_y,
  output logic                           fire_ack,
  output logic                           update_busy
);

  localparam int IDX_W = $clog2(NUM_BULLETS);
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);

  bullet_t          slots [NUM_BULLETS];
  sched_state_e     state, state_n;
  logic [IDX_W-1:0] upd_idx, upd_idx_n;
  logic [CD_W-1:0]  cooldown;
  logic             pending, fire_q;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic             fire_rise, serve, spawn, reject;

  bullet_slot_alloc #(
    .NUM_BULLETS (NUM_BULLETS),
    .IDX_W       (IDX_W)
  ) u_alloc (
    .live_mask (bullet_active),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  // fire_q powers up at 1 so a button held through reset is not an edge.
  assign fire_rise = fire & ~fire_q;

  // A pending request is resolved only in a quiet IDLE cycle; a frame_tick
  // in the same cycle starts the update first and the request waits for it.
  assign serve  = pending && (state == IDLE) && !frame_tick;
  assign spawn  = serve && (cooldown == '0) && any_free;
  assign reject = serve && !((cooldown == '0) && any_free);

  always_comb begin
    state_n   = state;
    upd_idx_n = upd_idx;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_n   = UPDATE;
          upd_idx_n = '0;
        end
      end
      UPDATE: begin
        // frame_tick is deliberately ignored here: no restart, no queueing.
        if (upd_idx == IDX_W'(NUM_BULLETS-1)) state_n = IDLE;
        else                                  upd_idx_n = upd_idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      upd_idx     <= '0;
      fire_q      <= 1'b1;
      pending     <= 1'b0;
      cooldown    <= '0;
      fire_ack    <= 1'b0;
      update_busy <= 1'b0;
    end else begin
      state       <= state_n;
      upd_idx     <= upd_idx_n;
      fire_q      <= fire;
      fire_ack    <= spawn;
      update_busy <= (state_n == UPDATE);

      // Resolution wins over a new rise: pending holds at most one shot.
      if (spawn || reject) pending <= 1'b0;
      else if (fire_rise)  pending <= 1'b1;

      if (spawn)
        cooldown <= frame_tick ? CD_W'(COOLDOWN_FRAMES-1) : CD_W'(COOLDOWN_FRAMES);
      else if (frame_tick && (cooldown != '0))
        cooldown <= cooldown - 1'b1;
    end
  end

  // Per-slot priority: spawn (only ever into a free slot) > hit > frame update.
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BULLETS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (spawn && (free_idx == IDX_W'(i))) begin
          slots[i] <= '{active: 1'b1, x: ship_x, y: Y_W'(SHIP_Y)};
        end else if (hit_valid && (hit_slot == IDX_W'(i))) begin
          slots[i].active <= 1'b0;
        end else if ((state == UPDATE) && (upd_idx == IDX_W'(i)) && slots[i].active) begin
          // Retire instead of subtracting past zero.
          if (slots[i].y < Y_W'(BULLET_SPEED)) slots[i] <= '0;
          else                                 slots[i].y <= slots[i].y - Y_W'(BULLET_SPEED);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_flat
    assign bullet_active[g]         = slots[g].active;
    assign bullet_x[g*X_W +: X_W]   = slots[g].x;
    assign bullet_y[g*Y_W +: Y_W]   = slots[g].y;
  end

endmodule
